// File: rtl/egress_queue_pkg.sv
// Shared constants for the egress queue slice.
//   DEFAULT_PACKET_CNT : default queue depth in entries
//   DEFAULT_META_WIDTH : default width of one metadata entry
//   DROP_CNT_WIDTH     : width of the refused-write counter
//   SKID_DEPTH         : number of entries held in the output skid stage
package egress_queue_pkg;

  localparam int DEFAULT_PACKET_CNT = 1024;
  localparam int DEFAULT_META_WIDTH = 32;
  localparam int DROP_CNT_WIDTH     = 16;
  localparam int SKID_DEPTH         = 2;

  typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

endpackage

// File: rtl/egress_queue_mem.sv
// simple_dual_port_mem: one write port, one synchronous read port, single clock.
// Read data is registered (1-cycle latency). When a read and a write hit the
// same address in the same cycle the read returns the data being written, so
// an entry written into an empty queue can be fetched in its own write cycle.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates only when high
//   rd_addr  : read address
//   rd_data  : registered read data
module simple_dual_port_mem
  import egress_queue_pkg::*;
#(
  parameter int MEM_SIZE   = DEFAULT_PACKET_CNT,
  parameter int DATA_WIDTH = DEFAULT_META_WIDTH
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(MEM_SIZE)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [$clog2(MEM_SIZE)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first on address collision.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/egress_queue.sv
// egress_queue: metadata FIFO between the crossbar and the egress consumer.
// Storage is a synchronous-read memory followed by a 2-entry skid stage that
// presents the head entry. Reads are issued only when the skid stage can
// absorb the returning data, so the consumer can pop one entry per cycle.
// Ports:
//   clk              : clock, all state on rising edge
//   reset            : asynchronous active-low reset
//   egress_in        : entry from the crossbar
//   egress_in_en     : write strobe (refused and counted while full)
//   flush            : synchronous clear of all queued entries
//   egress_in_ack    : consumer pops the head entry
//   egress_out       : head entry (meaningful while egress_out_valid)
//   egress_out_valid : head entry present
//   full/empty/almost_full : registered occupancy flags
//   count            : entries held, including the skid stage
//   drop_cnt         : saturating count of refused writes
module egress_queue
  import egress_queue_pkg::*;
#(
  parameter int PACKET_CNT   = DEFAULT_PACKET_CNT,
  parameter int META_WIDTH   = DEFAULT_META_WIDTH,
  parameter int AFULL_THRESH = PACKET_CNT - 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [META_WIDTH-1:0]         egress_in,
  input  logic                          egress_in_en,
  input  logic                          flush,
  input  logic                          egress_in_ack,
  output logic [META_WIDTH-1:0]         egress_out,
  output logic                          egress_out_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic [$clog2(PACKET_CNT):0]   count,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
);

  localparam int PTR_W = $clog2(PACKET_CNT);
  localparam int CNT_W = PTR_W + 1;

  function automatic drop_cnt_t sat_inc_drop(input drop_cnt_t v);
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      mem_cnt;      // entries in memory not yet read out
  logic [CNT_W-1:0]      mem_cnt_nxt;
  logic [CNT_W-1:0]      count_nxt;

  logic                  wr_acc;
  logic                  pop;
  logic                  drop;
  logic                  rd_issue;

  logic                  rd_vld_p1;
  logic [META_WIDTH-1:0] rd_data_p1;

  logic [1:0]            skid_cnt;
  logic [1:0]            skid_cnt_nxt;
  logic [1:0]            skid_occ_after;
  logic [META_WIDTH-1:0] skid0_p2;
  logic [META_WIDTH-1:0] skid1_p2;
  logic [META_WIDTH-1:0] skid0_nxt;
  logic [META_WIDTH-1:0] skid1_nxt;

  assign wr_acc = egress_in_en && !full && !flush;
  assign drop   = egress_in_en &&  full && !flush;
  assign pop    = egress_out_valid && egress_in_ack && !flush;

  // Skid occupancy once this cycle's pop and the in-flight read are settled;
  // a new read is issued only if that still leaves a free slot.
  assign skid_occ_after = skid_cnt - {1'b0, pop} + {1'b0, rd_vld_p1};
  assign rd_issue = !flush && ((mem_cnt != '0) || wr_acc) &&
                    (skid_occ_after < 2'(SKID_DEPTH));

  assign egress_out = skid0_p2;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !wr_acc) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    if (flush) begin
      mem_cnt_nxt = '0;
    end else if (wr_acc && !rd_issue) begin
      mem_cnt_nxt = mem_cnt + CNT_W'(1);
    end else if (rd_issue && !wr_acc) begin
      mem_cnt_nxt = mem_cnt - CNT_W'(1);
    end
  end

  // Stage p0 -> p1: memory read issued, data returns next cycle
  simple_dual_port_mem #(
    .MEM_SIZE   (PACKET_CNT),
    .DATA_WIDTH (META_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (egress_in),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_p1)
  );

  // Stage p1 -> p2: returning read data enters the skid stage
  always_comb begin
    skid_cnt_nxt = skid_cnt;
    skid0_nxt    = skid0_p2;
    skid1_nxt    = skid1_p2;
    if (flush) begin
      skid_cnt_nxt = '0;
      skid0_nxt    = '0;
      skid1_nxt    = '0;
    end else begin
      unique case ({rd_vld_p1, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            skid0_nxt = rd_data_p1;
          end else begin
            skid1_nxt = rd_data_p1;
          end
          skid_cnt_nxt = skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0_nxt    = skid1_p2;
          skid_cnt_nxt = skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0_nxt = rd_data_p1;
          end else begin
            skid0_nxt = skid1_p2;
            skid1_nxt = rd_data_p1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      mem_cnt          <= '0;
      count            <= '0;
      drop_cnt         <= '0;
      rd_vld_p1        <= 1'b0;
      skid_cnt         <= '0;
      skid0_p2         <= '0;
      skid1_p2         <= '0;
      egress_out_valid <= 1'b0;
      full             <= 1'b0;
      empty            <= 1'b1;
      almost_full      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (rd_issue) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
      if (drop) begin
        drop_cnt <= sat_inc_drop(drop_cnt);
      end
      mem_cnt          <= mem_cnt_nxt;
      count            <= count_nxt;
      rd_vld_p1        <= rd_issue;
      skid_cnt         <= skid_cnt_nxt;
      skid0_p2         <= skid0_nxt;
      skid1_p2         <= skid1_nxt;
      egress_out_valid <= (skid_cnt_nxt != 2'd0);
      full             <= (count_nxt == CNT_W'(PACKET_CNT));
      empty            <= (count_nxt == '0);
      almost_full      <= (count_nxt >= CNT_W'(AFULL_THRESH));
    end
  end

endmodule

// File: tb/tb_egress_queue.sv
// Directed self-checking bench for egress_queue with a 16-entry queue.
module tb_egress_queue;

  localparam int PC = 16;
  localparam int MW = 32;
  localparam int CW = $clog2(PC) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [MW-1:0] egress_in = '0;
  logic          egress_in_en = 1'b0;
  logic          flush = 1'b0;
  logic          egress_in_ack = 1'b0;
  logic [MW-1:0] egress_out;
  logic          egress_out_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  egress_queue #(
    .PACKET_CNT (PC),
    .META_WIDTH (MW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .egress_in        (egress_in),
    .egress_in_en     (egress_in_en),
    .flush            (flush),
    .egress_in_ack    (egress_in_ack),
    .egress_out       (egress_out),
    .egress_out_valid (egress_out_valid),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .count            (count),
    .drop_cnt         (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ri;
    int wi;
    bit ack_now;
    bit prev_hold;

    // Reset state
    repeat (3) tick();
    check_eq("rst_valid", egress_out_valid, 1'b0);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_afull", almost_full, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_out", egress_out, 0);
    reset = 1'b1;

    // Single entry latency: write in cycle 0, visible in cycle 2
    egress_in_en = 1'b1;
    egress_in    = 32'hA5;
    tick();
    egress_in_en = 1'b0;
    check_eq("lat_c1_valid", egress_out_valid, 1'b0);
    check_eq("lat_c1_count", count, 1);
    tick();
    check_eq("lat_c2_valid", egress_out_valid, 1'b1);
    check_eq("lat_c2_out", egress_out, 32'hA5);
    check_eq("lat_c2_count", count, 1);
    check_eq("lat_c2_empty", empty, 1'b0);
    egress_in_ack = 1'b1;
    tick();
    egress_in_ack = 1'b0;
    check_eq("lat_drain_empty", empty, 1'b1);
    check_eq("lat_drain_valid", egress_out_valid, 1'b0);

    // Back-to-back writes 1..8 with ack held high
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        check_eq($sformatf("b2b_valid_c%0d", c), egress_out_valid, 1'b1);
        check_eq($sformatf("b2b_out_c%0d", c), egress_out, c - 1);
      end
      egress_in_en  = (c < 8);
      egress_in     = c + 1;
      egress_in_ack = 1'b1;
      tick();
    end
    egress_in_en  = 1'b0;
    egress_in_ack = 1'b0;
    check_eq("b2b_empty", empty, 1'b1);
    check_eq("b2b_count", count, 0);
    check_eq("b2b_valid_end", egress_out_valid, 1'b0);

    // Overfill: 20 writes, 4 dropped
    for (int i = 0; i < 20; i++) begin
      egress_in_en = 1'b1;
      egress_in    = i + 1;
      tick();
      if (i == 10) check_eq("ovf_afull_11", almost_full, 1'b0);
      if (i == 11) check_eq("ovf_afull_12", almost_full, 1'b1);
      if (i == 14) check_eq("ovf_full_15", full, 1'b0);
      if (i == 15) begin
        check_eq("ovf_full_16", full, 1'b1);
        check_eq("ovf_count_16", count, 16);
      end
    end
    egress_in_en = 1'b0;
    check_eq("ovf_drop", drop_cnt, 4);
    check_eq("ovf_count", count, 16);
    egress_in_ack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("ovf_rd_valid%0d", k), egress_out_valid, 1'b1);
      check_eq($sformatf("ovf_rd_out%0d", k), egress_out, k + 1);
      tick();
    end
    egress_in_ack = 1'b0;
    check_eq("ovf_rd_empty", empty, 1'b1);

    // Full queue with simultaneous write and pop
    for (int i = 0; i < 16; i++) begin
      egress_in_en = 1'b1;
      egress_in    = 100 + i;
      tick();
    end
    check_eq("fwp_full", full, 1'b1);
    egress_in     = 32'hBEEF;
    egress_in_ack = 1'b1;
    tick();
    check_eq("fwp_count15", count, 15);
    check_eq("fwp_drop", drop_cnt, 5);
    check_eq("fwp_full_clr", full, 1'b0);
    egress_in     = 32'hCAFE;
    egress_in_ack = 1'b0;
    tick();
    egress_in_en = 1'b0;
    check_eq("fwp_count16", count, 16);
    check_eq("fwp_full_again", full, 1'b1);
    egress_in_ack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("fwp_rd%0d", k), egress_out, (k < 15) ? (101 + k) : 32'hCAFE);
      tick();
    end
    egress_in_ack = 1'b0;
    check_eq("fwp_empty", empty, 1'b1);

    // 40 entries with random ack, two pointer wraps
    ri = 0;
    wi = 0;
    prev_hold = 1'b0;
    for (int cyc = 0; cyc < 400 && ri < 40; cyc++) begin
      if (prev_hold) check_eq("rnd_hold_valid", egress_out_valid, 1'b1);
      ack_now = ($urandom_range(0, 3) != 0);
      if (egress_out_valid) begin
        check_eq($sformatf("rnd_out%0d", ri), egress_out, 200 + ri);
        if (ack_now) ri++;
      end
      prev_hold     = egress_out_valid && !ack_now;
      egress_in_en  = ((cyc % 2) == 0) && (wi < 40);
      egress_in     = 200 + wi;
      egress_in_ack = ack_now;
      if (egress_in_en) wi++;
      tick();
    end
    egress_in_en  = 1'b0;
    egress_in_ack = 1'b0;
    check_eq("rnd_all_read", ri, 40);
    tick();
    check_eq("rnd_empty", empty, 1'b1);
    check_eq("rnd_no_drop", drop_cnt, 5);

    // Flush with a same-cycle write and ack
    for (int i = 0; i < 5; i++) begin
      egress_in_en = 1'b1;
      egress_in    = 300 + i;
      tick();
    end
    egress_in_en = 1'b0;
    repeat (3) tick();
    check_eq("fl_pre_count", count, 5);
    flush         = 1'b1;
    egress_in_en  = 1'b1;
    egress_in     = 32'h999;
    egress_in_ack = 1'b1;
    tick();
    flush         = 1'b0;
    egress_in_en  = 1'b0;
    egress_in_ack = 1'b0;
    check_eq("fl_count", count, 0);
    check_eq("fl_empty", empty, 1'b1);
    check_eq("fl_valid", egress_out_valid, 1'b0);
    check_eq("fl_drop", drop_cnt, 5);
    repeat (2) tick();
    check_eq("fl_valid_later", egress_out_valid, 1'b0);
    check_eq("fl_count_later", count, 0);

    // Mid-operation asynchronous reset
    for (int i = 0; i < 5; i++) begin
      egress_in_en = 1'b1;
      egress_in    = 400 + i;
      tick();
    end
    egress_in_en = 1'b0;
    repeat (3) tick();
    check_eq("ar_pre_count", count, 5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_count", count, 0);
    check_eq("ar_empty", empty, 1'b1);
    check_eq("ar_valid", egress_out_valid, 1'b0);
    check_eq("ar_drop", drop_cnt, 0);
    check_eq("ar_out", egress_out, 0);
    tick();
    reset        = 1'b1;
    egress_in_en = 1'b1;
    egress_in    = 32'h77;
    tick();
    egress_in_en = 1'b0;
    check_eq("ar_first_wr", count, 1);
    tick();
    check_eq("ar_first_valid", egress_out_valid, 1'b1);
    check_eq("ar_first_out", egress_out, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_queue.md
EGRESS_QUEUE -- requirements
Module: egress_queue

Interface
REQ-001 The block SHALL have parameter PACKET_CNT, default 1024, meaning queue depth in entries (power of two, >= 4).
REQ-002 The block SHALL have parameter META_WIDTH, default 32, meaning the width of one metadata entry.
REQ-003 The block SHALL have parameter AFULL_THRESH, default PACKET_CNT-4, meaning the count at or above which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 egress_in  input  META_WIDTH  entry from the crossbar.
REQ-007 egress_in_en  input  1  write strobe, one entry per cycle.
REQ-008 flush  input  1  synchronous queue clear.
REQ-009 egress_in_ack  input  1  consumer pops the head entry.
REQ-010 egress_out  output  META_WIDTH  head entry; valid only while egress_out_valid is high.
REQ-011 egress_out_valid  output  1  head entry present.
REQ-012 full, empty, almost_full  output  1 each  occupancy flags.
REQ-013 count  output  $clog2(PACKET_CNT)+1  entries held, including the output stage.
REQ-014 drop_cnt  output  16  writes refused while full.

Function
REQ-015 A write SHALL be accepted when egress_in_en=1 and full=0, with full sampled from registered state before the edge.
REQ-016 egress_in_en=1 while full=1 SHALL discard the entry, leave all pointers unchanged, and increment drop_cnt, saturating at 16'hFFFF.
REQ-017 A pop SHALL occur only when egress_out_valid=1 and egress_in_ack=1; egress_in_ack while egress_out_valid=0 SHALL be ignored.
REQ-018 Write and read pointers SHALL be $clog2(PACKET_CNT) bits, SHALL increment by one, and SHALL wrap from PACKET_CNT-1 to 0.
REQ-019 Storage SHALL be a synchronous-read memory with 1-cycle read latency, followed by a 2-entry output skid stage.
REQ-020 An entry written in cycle N into an empty queue SHALL appear with egress_out_valid=1 in cycle N+2.
REQ-021 With egress_in_ack held high and the queue non-empty, one entry SHALL be popped per cycle with no bubble.
REQ-022 Entries SHALL leave in exactly the order they were accepted.
REQ-023 egress_out and egress_out_valid SHALL hold stable while egress_out_valid=1 and egress_in_ack=0.
REQ-024 count SHALL update as +1 on a write only, -1 on a pop only, and unchanged on a simultaneous write and pop.
REQ-025 full SHALL equal (count==PACKET_CNT), empty SHALL equal (count==0), and almost_full SHALL equal (count>=AFULL_THRESH); all three SHALL be registered.
REQ-026 A simultaneous write and pop while full=1 SHALL perform the pop and drop the write (REQ-016).
REQ-027 flush=1 SHALL, at the next edge, zero both pointers, count and the skid stage, deassert egress_out_valid, and ignore any same-cycle write or pop; drop_cnt SHALL be unaffected.
REQ-028 The skid stage SHALL issue a memory read only when it has a free slot, counting in-flight reads, so it never overflows.

Reset
REQ-029 On reset=0, the block SHALL clear asynchronously: pointers=0, count=0, drop_cnt=0, skid stage empty, egress_out_valid=0, full=0, almost_full=0, empty=1.
REQ-030 egress_out SHALL reset to 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued and in-flight entries; memory contents need not be cleared.
REQ-032 The first write SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-033 The shared package SHALL hold the default PACKET_CNT and META_WIDTH, and the DROP_CNT_WIDTH=16 constant.
REQ-034 Storage SHALL instantiate simple_dual_port_mem (MEM_SIZE=PACKET_CNT, DATA_WIDTH=META_WIDTH) as the single sub-module.
REQ-035 Pointer, count and skid-stage logic SHALL live in egress_queue itself.

Verification
REQ-036 Reset, then write 32'hA5 in cycle 0 with ack low -> egress_out_valid=1 and egress_out=32'hA5 in cycle 2; count=1; empty=0.
REQ-037 Write 1..8 back-to-back with ack held high -> outputs 1..8 on 8 consecutive cycles starting at cycle 2, then empty=1, count=0.
REQ-038 PACKET_CNT=16: write 20 entries with no ack -> full=1 after the 16th write, drop_cnt=4, almost_full=1 from count=12, and readout yields 1..16.
REQ-039 PACKET_CNT=16: full queue, write and ack in the same cycle -> count=15, drop_cnt +1; then write again -> count=16.
REQ-040 PACKET_CNT=16: push and pop 40 entries with random ack -> order preserved across two pointer wraps, and egress_out stays stable while ack=0.
REQ-041 Queue holding 5 entries, assert flush together with a write -> next cycle count=0, empty=1, egress_out_valid=0, drop_cnt unchanged; repeat using reset -> same result, asynchronously.
